// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter funnelling four register write requesters onto one write port; optional conflict_cnt via REG_WR_ARB_CONFLICT_CNT_EN.
// Latency: one cycle from handshake to wr_en/wr_addr/wr_data, one write per cycle with no bubbles.
// Backpressure: req_ready is a combinational one-hot grant; losers simply hold req_valid until granted.
module reg_write_arbiter #(
    parameter int N = 32,
    parameter int A = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [3:0]     req_valid,
    input  logic [4*A-1:0] req_addr,
    input  logic [4*N-1:0] req_data,
    output logic [3:0]     req_ready,
    output logic           wr_en,
    output logic [A-1:0]   wr_addr,
    output logic [N-1:0]   wr_data,
    output logic           busy
`ifdef REG_WR_ARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]    conflict_cnt
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t     state;
    state_t     nextState;
    logic [1:0] ptr;
    logic [1:0] grantIdx;
    logic       grantFound;
    logic       handshake;

    // Search ptr, ptr+1, ptr+2, ptr+3; the 2-bit sum wraps naturally.
    always_comb begin
        grantFound = 1'b0;
        grantIdx   = ptr;
        for (int k = 0; k < 4; k++) begin
            if (!grantFound && req_valid[ptr + 2'(k)]) begin
                grantFound = 1'b1;
                grantIdx   = ptr + 2'(k);
            end
        end
    end

    // Grant is masked by rst so nothing is accepted while reset is held.
    assign handshake = grantFound && !rst;
    assign req_ready = handshake ? (4'b0001 << grantIdx) : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (handshake) begin
            ptr <= grantIdx + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        wr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (handshake) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                wr_en = 1'b1;
                if (!handshake) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Payload is captured only on the handshake edge and held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr <= '0;
            wr_data <= '0;
        end else if (handshake) begin
            wr_addr <= req_addr[grantIdx*A +: A];
            wr_data <= req_data[grantIdx*N +: N];
        end
    end

    assign busy = (|req_valid) || wr_en;

`ifdef REG_WR_ARB_CONFLICT_CNT_EN
    logic multiValid;

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multiValid = |(req_valid & (req_valid - 4'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= 16'd0;
        end else if (multiValid && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized and directed bench for reg_write_arbiter with a queue-based scoreboard and a behavioural model.
module tb_reg_write_arbiter;

    localparam int N = 32;
    localparam int A = 4;

    typedef struct {
        logic         we;
        logic [A-1:0] addr;
        logic [N-1:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req_valid = '0;
    logic [4*A-1:0] req_addr = '0;
    logic [4*N-1:0] req_data = '0;
    logic [3:0]     req_ready;
    logic           wr_en;
    logic [A-1:0]   wr_addr;
    logic [N-1:0]   wr_data;
    logic           busy;
`ifdef REG_WR_ARB_CONFLICT_CNT_EN
    logic [15:0]    conflict_cnt;
`endif

    reg_write_arbiter #(.N(N), .A(A)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .busy(busy)
`ifdef REG_WR_ARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int passCnt = 0;
    int totalCnt = 0;

    exp_t         expQ[$];
    int           mPtr;
    logic         mPrevHs;
    logic [A-1:0] mLastAddr;
    logic [N-1:0] mLastData;
    int           mLastGrant;
    int           mWait[4];
    int           mConf;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic modelReset();
        mPtr = 0;
        mPrevHs = 1'b0;
        mLastAddr = '0;
        mLastData = '0;
        mLastGrant = -1;
        mConf = 0;
        for (int i = 0; i < 4; i++) mWait[i] = 0;
        expQ.delete();
    endtask

    // Monitor: shortly after each edge, the DUT's write port is compared against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                check("rst_wr_en", wr_en, 1'b0);
                check("rst_wr_addr", wr_addr, '0);
                check("rst_wr_data", wr_data, '0);
            end else if (expQ.size() > 0) begin
                e = expQ.pop_front();
                check("wr_en", wr_en, e.we);
                check("wr_addr", wr_addr, e.addr);
                check("wr_data", wr_data, e.data);
            end else begin
                check("idle_wr_en", wr_en, 1'b0);
            end
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = '0;
        modelReset();
        #3;
        check("rst_req_ready", req_ready, 4'b0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic step(input logic [3:0] v, input logic [4*A-1:0] ad, input logic [4*N-1:0] da);
        int g;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_addr = ad;
        req_data = da;
        #3;
        g = -1;
        for (int k = 0; k < 4; k++)
            if (g < 0 && v[(mPtr + k) % 4]) g = (mPtr + k) % 4;
        check("req_ready", req_ready, (g < 0) ? 4'b0000 : 4'(1 << g));
        check("busy", busy, (v != 4'b0000) || mPrevHs);
`ifdef REG_WR_ARB_CONFLICT_CNT_EN
        check("conflict_cnt", conflict_cnt, 16'(mConf));
        if ($countones(v) >= 2 && mConf < 65535) mConf++;
`endif
        for (int i = 0; i < 4; i++) begin
            if (g == i) begin
                check("starve_bound", mWait[i] <= 3, 1'b1);
                mWait[i] = 0;
            end else if (v[i]) mWait[i]++;
            else mWait[i] = 0;
        end
        if (g >= 0) begin
            mLastAddr = ad[g*A +: A];
            mLastData = da[g*N +: N];
            mPtr = (g + 1) % 4;
        end
        e.we = (g >= 0);
        e.addr = mLastAddr;
        e.data = mLastData;
        expQ.push_back(e);
        mPrevHs = (g >= 0);
        mLastGrant = g;
    endtask

    initial begin
        logic [3:0]     pend;
        logic [4*A-1:0] rAddr;
        logic [4*N-1:0] rData;

        modelReset();
        doReset();

        // Idle after reset: nothing granted, write port stays zero.
        repeat (5) step(4'b0000, '0, '0);

        // Single requester 2.
        step(4'b0100, {4'h0, 4'h3, 4'h0, 4'h0}, {32'h0, 32'h11111, 32'h0, 32'h0});
        step(4'b0000, '0, '0);
        step(4'b0000, '0, '0);

        // All four requesting from reset: 0,1,2,3,0,1,2,3.
        doReset();
        repeat (8) step(4'b1111, {4'hD, 4'hC, 4'hB, 4'hA},
                        {32'hEEEEE, 32'h77777, 32'h44444, 32'hAAAAA});
        step(4'b0000, '0, '0);

        // Move ptr to 2, then 4'b1010 grants 3 and wraps to 1.
        doReset();
        step(4'b0010, {4'h0, 4'h0, 4'h1, 4'h0}, {32'h0, 32'h0, 32'h12345, 32'h0});
        step(4'b1010, {4'h9, 4'h0, 4'h8, 4'h0}, {32'h99999, 32'h0, 32'h88888, 32'h0});
        check("ptr_wrap_grant3", mLastGrant, 3);
        step(4'b1010, {4'h9, 4'h0, 4'h8, 4'h0}, {32'h99999, 32'h0, 32'h88888, 32'h0});
        check("ptr_wrap_grant1", req_ready, 4'b0010);
        step(4'b0000, '0, '0);

        // Reset asserted during a would-be handshake discards it.
        @(posedge clk);
        #1;
        req_valid = 4'b0001;
        req_addr = {4'h0, 4'h0, 4'h0, 4'h5};
        req_data = {32'h0, 32'h0, 32'h0, 32'h22222};
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        check("midrst_req_ready", req_ready, 4'b0000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = 4'b0000;
        step(4'b1000, {4'h6, 4'h0, 4'h0, 4'h0}, {32'h66666, 32'h0, 32'h0, 32'h0});
        step(4'b0000, '0, '0);

`ifdef REG_WR_ARB_CONFLICT_CNT_EN
        doReset();
        repeat (10) step(4'b0011, {4'h0, 4'h0, 4'h2, 4'h1}, {32'h0, 32'h0, 32'h2, 32'h1});
        repeat (3) step(4'b0001, {4'h0, 4'h0, 4'h0, 4'h1}, {32'h0, 32'h0, 32'h0, 32'h1});
        step(4'b0000, '0, '0);
        check("conflict_10", conflict_cnt, 16'd10);
        doReset();
        check("conflict_rst", conflict_cnt, 16'd0);
`endif

        // Random traffic: requesters hold valid until granted, occasionally withdraw.
        doReset();
        pend = 4'b0000;
        for (int n = 0; n < 400; n++) begin
            pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) pend[$urandom_range(0, 3)] = 1'b0;
            rAddr = 16'($urandom);
            rData = {$urandom, $urandom, $urandom, $urandom};
            step(pend, rAddr, rData);
            if (mLastGrant >= 0) pend[mLastGrant] = 1'b0;
            if (n == 200) doReset();
        end
        repeat (3) step(4'b0000, '0, '0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter N, default 32, data width of the shared register write port.
REQ-002 Parameter A, default 4, register address width (2^A registers).
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 req_valid  input  4  per-requester write request, bit i = requester i.
REQ-006 req_addr  input  4*A  packed target addresses, requester i at bits [i*A +: A].
REQ-007 req_data  input  4*N  packed write data, requester i at bits [i*N +: N].
REQ-008 req_ready  output  4  one-hot grant, bit i high = requester i accepted this cycle.
REQ-009 wr_en  output  1  write enable to register file, drives register en.
REQ-010 wr_addr  output  A  register file write address.
REQ-011 wr_data  output  N  register file write data, drives register D.
REQ-012 busy  output  1  high while any req_valid bit is set or wr_en is high.

Function
REQ-013 Handshake: transfer of requester i occurs in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-014 req_ready is combinational from req_valid and the priority pointer; at most one bit high per cycle; all zero when req_valid is zero.
REQ-015 Round-robin: search starts at pointer ptr (2 bits) and proceeds ptr, ptr+1, ptr+2, ptr+3 mod 4; first valid requester is granted.
REQ-016 After a handshake with requester i, ptr becomes (i+1) mod 4 on the next edge; ptr unchanged when no handshake.
REQ-017 Latency: handshake in cycle k produces wr_en=1 with that requester's addr/data registered in cycle k+1, held exactly one cycle.
REQ-018 Throughput: one grant per cycle; back-to-back grants produce back-to-back wr_en pulses with no bubble.
REQ-019 Cycle with no handshake: wr_en=0 in next cycle; wr_addr and wr_data hold their last values.
REQ-020 Two-state FSM: IDLE (wr_en=0) and WRITE (wr_en=1); IDLE->WRITE on handshake; WRITE->WRITE on handshake; WRITE->IDLE on no handshake.
REQ-021 A requester deasserting req_valid before grant is dropped without side effects; payload is sampled only on the handshake edge.
REQ-022 Starvation bound: a continuously valid requester is granted within 4 cycles.

Reset
REQ-023 While rst is high: req_ready=0, wr_en=0, wr_addr=0, wr_data=0, ptr=0, FSM=IDLE, independent of clk.
REQ-024 rst asserted mid-operation discards any pending write; no wr_en pulse appears in the cycle after rst deasserts unless a new handshake occurs.
REQ-025 First cycle after rst deassertion grants lowest-index valid requester (ptr=0).

Configuration
REQ-026 Macro REG_WR_ARB_CONFLICT_CNT_EN defined: add output conflict_cnt (16 bits), incremented each cycle with two or more req_valid bits set, saturating at 16'hFFFF, cleared to 0 by rst.
REQ-027 Macro REG_WR_ARB_CONFLICT_CNT_EN undefined: conflict_cnt port and counter absent; all other behaviour identical.

Verification
REQ-028 rst pulse then req_valid=4'b0000 for 5 cycles -> req_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0 throughout.
REQ-029 Only requester 2 valid, addr=4'h3, data=32'h11111 -> req_ready=4'b0100 same cycle; next cycle wr_en=1, wr_addr=3, wr_data=32'h11111; following cycle wr_en=0.
REQ-030 req_valid=4'b1111 held 8 cycles from reset -> grant order 0,1,2,3,0,1,2,3; wr_en high 8 consecutive cycles, wr_data matches each grantee's data (e.g. 32'hAAAAA, 32'h44444, 32'h77777, 32'hEEEEE).
REQ-031 req_valid=4'b1010 with ptr=2 -> requester 3 granted, ptr becomes 0; next cycle requester 1 granted.
REQ-032 rst asserted in the cycle of a handshake (data 32'h22222) -> wr_en stays 0, wr_data stays 0, ptr=0 after release.
REQ-033 With REG_WR_ARB_CONFLICT_CNT_EN: req_valid=4'b0011 for 10 cycles then 4'b0001 for 3 -> conflict_cnt=10; rst -> conflict_cnt=0.
